// File: rtl/dct_stream_pkg.sv
// Shared types, default sizes and the read-address mapping for the DCT block streamer.
package dct_stream_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_N  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // N is a power of two, so idx%N and idx/N reduce to a mask and a shift by lg = log2(N).
    function automatic logic [31:0] rd_addr(input logic [31:0] idx, input logic col_major,
                                            input int lg);
        logic [31:0] mask;
        mask = (32'd1 << lg) - 32'd1;
        if (col_major)
            rd_addr = ((idx & mask) << lg) | (idx >> lg);
        else
            rd_addr = idx;
    endfunction

endpackage

// File: rtl/dct_block_ram.sv
// N*N x DW block register file: one synchronous write port, one combinational read port.
module dct_block_ram
    import dct_stream_pkg::*;
#(
    parameter int  DW = DEF_DW,
    parameter int  N  = DEF_N,
    localparam int AW = $clog2(N * N)
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_sel,
    output logic [DW-1:0] rd_data
);

    // Contents deliberately survive reset so a loaded block can be replayed after RST_N.
    logic [DW-1:0] mem [N * N];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_sel];

endmodule

// File: rtl/dct_block_streamer.sv
// Replays a stored NxN pixel block repeat_cnt times over a valid/ready stream with sob/eob markers.
// Optional column-major replay is enabled by defining DCT_STREAM_TRANSPOSE_EN (adds port col_major).
module dct_block_streamer
    import dct_stream_pkg::*;
#(
    parameter int  DW    = DEF_DW,
    parameter int  N     = DEF_N,
    parameter int  RPT_W = 8,
    localparam int AW    = $clog2(N * N)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             start,
    input  logic [RPT_W-1:0] repeat_cnt,
    input  logic             abort,
`ifdef DCT_STREAM_TRANSPOSE_EN
    input  logic             col_major,
`endif
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    xout,
    output logic             xout_valid,
    input  logic             xout_ready,
    output logic             xout_sob,
    output logic             xout_eob
);

    localparam int            LG       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    nidx;
    logic [AW-1:0]    ram_addr;
    logic [RPT_W-1:0] blk;
    logic [RPT_W-1:0] nblk;
    logic [RPT_W-1:0] rpt_q;
    logic [DW-1:0]    ram_q;
    logic             cm_sel;
    logic             cm_q;
    logic             xfer;
    logic             last_xfer;
    logic             ram_we;

`ifdef DCT_STREAM_TRANSPOSE_EN
    assign cm_sel = col_major;
`else
    assign cm_sel = 1'b0;
`endif

    assign busy      = (state == STREAM);
    assign ram_we    = wr_en && (state == IDLE);
    assign xfer      = xout_valid && xout_ready;
    assign last_xfer = xfer && xout_eob && (blk == rpt_q - 1'b1);

    // idx/blk describe the sample held in the output register; nidx/nblk the one to fetch next.
    always_comb begin
        nidx = '0;
        nblk = '0;
        if (xout_valid) begin
            nidx = xout_eob ? '0 : idx + 1'b1;
            nblk = xout_eob ? blk + 1'b1 : blk;
        end
    end

    assign ram_addr = AW'(rd_addr(32'(nidx), cm_q, LG));

    dct_block_ram #(
        .DW (DW),
        .N  (N)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_sel  (ram_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            idx        <= '0;
            blk        <= '0;
            rpt_q      <= '0;
            cm_q       <= 1'b0;
            xout       <= '0;
            xout_valid <= 1'b0;
            xout_sob   <= 1'b0;
            xout_eob   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (repeat_cnt != '0) begin
                        state <= STREAM;
                        rpt_q <= repeat_cnt;
                        idx   <= '0;
                        blk   <= '0;
                        cm_q  <= cm_sel;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else begin
                // The final transfer outranks a coincident abort.
                if (last_xfer) begin
                    state      <= IDLE;
                    xout_valid <= 1'b0;
                    xout_sob   <= 1'b0;
                    xout_eob   <= 1'b0;
                    done       <= 1'b1;
                end else if (abort) begin
                    state      <= IDLE;
                    xout_valid <= 1'b0;
                    xout_sob   <= 1'b0;
                    xout_eob   <= 1'b0;
                end else if (!xout_valid || xout_ready) begin
                    idx        <= nidx;
                    blk        <= nblk;
                    xout       <= ram_q;
                    xout_valid <= 1'b1;
                    xout_sob   <= (nidx == '0);
                    xout_eob   <= (nidx == LAST_IDX);
                end
            end
        end
    end

endmodule
